// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one column per cycle through a shared transformer.
// Define INV_MIX_COLS_PARALLEL_EN to transform all four columns in a single cycle.
module inv_mix_columns_seq (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e       fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [1:0]   col_q, col_d;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by 09/0B/0D/0E from the x2, x4, x8 xtime chain.
   function automatic logic [7:0] mul_9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Every output row is the same coefficient pattern rotated across the column.
   function automatic logic [7:0] inv_row(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
      return mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
              inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
   endfunction

`ifndef INV_MIX_COLS_PARALLEL_EN
   logic [31:0] col_in, col_out;

   always_comb begin
      col_in = state_q[127:96];
      unique case (col_q)
         2'd0: col_in = state_q[127:96];
         2'd1: col_in = state_q[95:64];
         2'd2: col_in = state_q[63:32];
         2'd3: col_in = state_q[31:0];
      endcase
   end

   assign col_out = inv_col(col_in);
`endif

   always_comb begin
      fsm_d     = fsm_q;
      state_d   = state_q;
      col_d     = col_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (fsm_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = in;
               col_d   = 2'd0;
               fsm_d   = StBusy;
            end
         end
         StBusy: begin
`ifdef INV_MIX_COLS_PARALLEL_EN
            state_d = {inv_col(state_q[127:96]), inv_col(state_q[95:64]),
                       inv_col(state_q[63:32]), inv_col(state_q[31:0])};
            fsm_d   = StDone;
`else
            unique case (col_q)
               2'd0: state_d[127:96] = col_out;
               2'd1: state_d[95:64]  = col_out;
               2'd2: state_d[63:32]  = col_out;
               2'd3: state_d[31:0]   = col_out;
            endcase
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               fsm_d = StDone;
            end
`endif
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   assign out = out_valid ? state_q : 128'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= StIdle;
         state_q <= 128'h0;
         col_q   <= 2'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         col_q   <= col_d;
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq against a GF(2^8) matrix model.
// Honours INV_MIX_COLS_PARALLEL_EN for latency and streaming spacing.
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int total  = 0;
   int passed = 0;

`ifdef INV_MIX_COLS_PARALLEL_EN
   localparam int Lat     = 1;
   localparam int Spacing = 3;
`else
   localparam int Lat     = 4;
   localparam int Spacing = 6;
`endif

   inv_mix_columns_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_data)
   );

   always #5 clk = ~clk;

   // Shift-and-add GF(2^8) multiply, modulus 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Circulant matrix product per column: row r uses coefficient coef[(k - r) mod 4] for byte k.
   function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
      logic [7:0]   coef [4];
      logic [7:0]   a [4];
      logic [7:0]   acc;
      logic [127:0] r;
      coef = '{c0, c1, c2, c3};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - row + 4) % 4], a[k]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_ref(input logic [127:0] s);
      return mix_ref(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
   endfunction

   function automatic logic [127:0] fwd_ref(input logic [127:0] s);
      return mix_ref(s, 8'h02, 8'h03, 8'h01, 8'h01);
   endfunction

   function automatic logic [127:0] rand_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Offers s, waits for acceptance and out_valid; lat = edges from accept to out_valid, -1 on timeout.
   task automatic push(input logic [127:0] s, output int lat);
      int n;
      lat = -1;
      @(negedge clk);
      in_data  = s;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (out_valid) begin
         lat = 0;
         return;
      end
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      total++;
      if (out_data !== 128'h0) $display("FAIL reset_out: got %h want 0", out_data);
      else passed++;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL reset_flags: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_known_vector();
      logic [127:0] kv, exp;
      int lat;
      kv  = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
      exp = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
      push(kv, lat);
      total++;
      if (lat !== Lat) $display("FAIL kv_latency: got %0d want %0d", lat, Lat);
      else passed++;
      total++;
      if (out_data !== exp) $display("FAIL kv_out: got %h want %h", out_data, exp);
      else passed++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL kv_ready_in_done: got %b want 0", in_ready);
      else passed++;
      pop();
   endtask

   task automatic test_round_trip();
      logic [127:0] s;
      int lat;
      for (int i = 0; i < 1000; i++) begin
         s = rand_state();
         push(fwd_ref(s), lat);
         total++;
         if (lat !== Lat || out_data !== s) begin
            $display("FAIL round_trip[%0d]: got %h lat %0d want %h lat %0d",
                     i, out_data, lat, s, Lat);
            pop();
            break;
         end else passed++;
         pop();
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] s, hold;
      int lat;
      bit ok;
      s = rand_state();
      push(s, lat);
      hold = out_data;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_data !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      total++;
      if (lat !== Lat) $display("FAIL bp_latency: got %0d want %0d", lat, Lat);
      else passed++;
      total++;
      if (!ok) $display("FAIL bp_stable: got unstable/handshake change want held result");
      else passed++;
      total++;
      if (out_data !== inv_ref(s)) $display("FAIL bp_out: got %h want %h", out_data, inv_ref(s));
      else passed++;
      pop();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_ignore_busy();
      logic [127:0] a, b;
      int lat;
      bit ok;
      a = rand_state();
      b = rand_state();
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL ib_idle: got %b want 1", in_ready);
      else passed++;
      in_data  = a;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_data = b;
      ok  = 1'b1;
      lat = -1;
      for (int i = 1; i <= 50; i++) begin
         if (in_ready !== 1'b0) ok = 1'b0;
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         if (out_data !== inv_ref(a) || in_ready !== 1'b0) ok = 1'b0;
      end
      total++;
      if (lat !== Lat) $display("FAIL ib_latency: got %0d want %0d", lat, Lat);
      else passed++;
      total++;
      if (out_data !== inv_ref(a)) $display("FAIL ib_first: got %h want %h", out_data, inv_ref(a));
      else passed++;
      total++;
      if (!ok) $display("FAIL ib_no_accept: got early accept or changed result want none");
      else passed++;
      pop();
      // Back in IDLE with in_valid still high: b goes in at the next edge.
      @(posedge clk);
      #1 in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0) $display("FAIL ib_second_accept: got in_ready=%b want 0", in_ready);
      else passed++;
      lat = -1;
      for (int i = 1; i <= 50; i++) begin
         if (out_valid) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (lat < 0 || out_data !== inv_ref(b))
         $display("FAIL ib_second: got %h want %h", out_data, inv_ref(b));
      else passed++;
      pop();
   endtask

   task automatic test_reset_mid();
      logic [127:0] s, v;
      int lat;
      bit ok;
      s = rand_state();
      @(negedge clk);
      in_data  = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if (out_data !== 128'h0 || out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mid_reset: got out=%h out_valid=%b in_ready=%b want 0/0/1",
                  out_data, out_valid, in_ready);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL mid_discard: got stale activity want idle");
      else passed++;
      v = {4{32'h2D26314C}};
      push(v, lat);
      total++;
      if (lat !== Lat || out_data !== inv_ref(v))
         $display("FAIL post_reset_a: got %h lat %0d want %h", out_data, lat, inv_ref(v));
      else passed++;
      pop();
      // 2D26314C -> 4D7EBDF8 is the forward direction, so the inverse maps it back.
      v = {4{32'h4D7EBDF8}};
      push(v, lat);
      total++;
      if (lat !== Lat || out_data !== {4{32'h2D26314C}})
         $display("FAIL post_reset_b: got %h lat %0d want %h", out_data, lat, {4{32'h2D26314C}});
      else passed++;
      pop();
   endtask

   task automatic test_back_to_back();
      logic [127:0] src [5];
      logic [127:0] res [$];
      int acc_t [$];
      int idx;
      for (int i = 0; i < 5; i++) src[i] = rand_state();
      idx = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (idx < 5) begin
            in_data  = src[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) res.push_back(out_data);
         if (in_valid && in_ready) begin
            acc_t.push_back(cyc);
            idx++;
         end
         if (res.size() == 5) break;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      total++;
      if (res.size() != 5) $display("FAIL b2b_count: got %0d want 5", res.size());
      else passed++;
      for (int i = 0; i < res.size(); i++) begin
         total++;
         if (res[i] !== inv_ref(src[i]))
            $display("FAIL b2b_out[%0d]: got %h want %h", i, res[i], inv_ref(src[i]));
         else passed++;
      end
      for (int i = 1; i < acc_t.size(); i++) begin
         total++;
         if (acc_t[i] - acc_t[i-1] != Spacing)
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_t[i] - acc_t[i-1], Spacing);
         else passed++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_known_vector();
      test_round_trip();
      test_backpressure();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
